// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: the FSM state type,
// common mouse command bytes and helpers that turn microseconds into cycles.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] PS2_ACK          = 8'hFA;

   localparam int unsigned PS2_CLK_FREQ_HZ = 65_000_000;
   localparam int unsigned PS2_INHIBIT_US  = 100;
   localparam int unsigned PS2_TIMEOUT_US  = 15_000;

   // Retries after the first attempt when the retry build option is on.
   localparam logic [1:0] PS2_RETRY_MAX = 2'd2;

   function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                input int unsigned us);
      return (clk_hz / 1_000_000) * us;
   endfunction

   localparam int unsigned PS2_INHIBIT_CYCLES = us_to_cycles(PS2_CLK_FREQ_HZ, PS2_INHIBIT_US);
   localparam int unsigned PS2_TIMEOUT_CYCLES = us_to_cycles(PS2_CLK_FREQ_HZ, PS2_TIMEOUT_US);

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-collector PS/2 pad plus a registered
// falling-edge flag (pad-to-flag latency of three cycles).
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic pad_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic fall_q, fall_d;

   // Next state: shift the pad through the chain, flag a synced 1 -> 0 step
   always_comb begin
      meta_d = pad_i;
      sync_d = meta_q;
      prev_d = sync_q;
      fall_d = prev_q & ~sync_q;
   end

   // Registers; idle bus level is high so reset to 1 to avoid a false edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         fall_q <= fall_d;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte per request:
// inhibit, request-to-send, 10 device-clocked bits, ACK sample, wait idle.
// Build option PS2_TX_RETRY_EN: resend a NACKed/timed-out byte up to twice
// before reporting tx_err.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = PS2_CLK_FREQ_HZ,
   parameter int unsigned INHIBIT_US  = PS2_INHIBIT_US,
   parameter int unsigned TIMEOUT_US  = PS2_TIMEOUT_US
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned INHIBIT_CYCLES = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
   localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
   localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       STOP_IDX = 4'd9;

   ps2_tx_state_t     state_q, state_d;
   logic [7:0]        byte_q, byte_d;
   logic              parity_q, parity_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              nack_q, nack_d;
   logic              clk_oe_q, clk_oe_d;
   logic              data_oe_q, data_oe_d;
   logic              tx_ready_q, tx_ready_d;
   logic              tx_done_q, tx_done_d;
   logic              tx_err_q, tx_err_d;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]        retry_cnt_q, retry_cnt_d;
`endif

   logic              clk_sync, clk_fall;
   logic              data_sync, data_fall_unused;
   logic [9:0]        frame;
   logic              accept;
   logic              start, fail;

   ps2_line_sync u_clk_sync (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (ps2_clk_in),
      .sync_o (clk_sync),
      .fall_o (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (ps2_data_in),
      .sync_o (data_sync),
      .fall_o (data_fall_unused)
   );

   // Bits in send order: data LSB first, odd parity, stop (released line)
   assign frame  = {1'b1, parity_q, byte_q};
   assign accept = tx_valid & tx_ready_q;

   // Next-state and registered-output logic for the transfer FSM
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      parity_d   = parity_q;
      bit_cnt_d  = bit_cnt_q;
      inh_cnt_d  = inh_cnt_q;
      to_cnt_d   = to_cnt_q;
      nack_d     = nack_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      tx_done_d  = 1'b0;
      tx_err_d   = 1'b0;
      start      = 1'b0;
      fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               byte_d   = tx_data;
               parity_d = ~^tx_data;
               start    = 1'b1;
`ifdef PS2_TX_RETRY_EN
               retry_cnt_d = 2'd0;
`endif
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               state_d   = ST_RTS;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         ST_RTS: begin
            clk_oe_d = 1'b0;
            to_cnt_d = '0;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (clk_fall) begin
               data_oe_d = ~frame[bit_cnt_q];
               if (bit_cnt_q == STOP_IDX) begin
                  state_d = ST_ACK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               nack_d  = data_sync;
               state_d = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               if (nack_q) begin
                  fail = 1'b1;
               end else begin
                  tx_done_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Timeout watchdog from clock release; overrides any edge this cycle
      if (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
         to_cnt_d = to_cnt_q + 1'b1;
         if (to_cnt_q == TO_LAST) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            tx_done_d = 1'b0;
            fail      = 1'b1;
         end
      end

      if (fail) begin
`ifdef PS2_TX_RETRY_EN
         if (retry_cnt_q < PS2_RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            start       = 1'b1;
         end else begin
            tx_err_d = 1'b1;
            state_d  = ST_IDLE;
         end
`else
         tx_err_d = 1'b1;
         state_d  = ST_IDLE;
`endif
      end

      // Begin (or restart) an attempt from the inhibit phase
      if (start) begin
         state_d   = ST_INHIBIT;
         clk_oe_d  = 1'b1;
         data_oe_d = 1'b0;
         inh_cnt_d = '0;
         bit_cnt_d = '0;
         nack_d    = 1'b0;
      end

      // Ready drops on the completion pulse and returns the cycle after
      tx_ready_d = (state_d == ST_IDLE) && !tx_done_d && !tx_err_d;
   end

   // State and output registers; reset releases both lines immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_q     <= '0;
         parity_q   <= 1'b0;
         bit_cnt_q  <= '0;
         inh_cnt_q  <= '0;
         to_cnt_q   <= '0;
         nack_q     <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         tx_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
         tx_err_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         parity_q   <= parity_d;
         bit_cnt_q  <= bit_cnt_d;
         inh_cnt_q  <= inh_cnt_d;
         to_cnt_q   <= to_cnt_d;
         nack_q     <= nack_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         tx_ready_q <= tx_ready_d;
         tx_done_q  <= tx_done_d;
         tx_err_q   <= tx_err_d;
`ifdef PS2_TX_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_ready    = tx_ready_q;
   assign tx_done     = tx_done_q;
   assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host,
// ACKs or NACKs them, and checks timing, bit order and completion pulses.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int unsigned CLK_HZ = 2_000_000;
   localparam int unsigned INH_US = 100;
   localparam int unsigned TO_US  = 1_000;
   localparam int INH_CYC = (CLK_HZ / 1_000_000) * INH_US;
   localparam int TO_CYC  = (CLK_HZ / 1_000_000) * TO_US;
`ifdef PS2_TX_RETRY_EN
   localparam int ATTEMPTS = 3;
`else
   localparam int ATTEMPTS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err;

   int total = 0;
   int bad = 0;

   // Open-collector bus: either side pulling low wins
   assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low;
   assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

   ps2_host_tx #(
      .CLK_FREQ_HZ (CLK_HZ),
      .INHIBIT_US  (INH_US),
      .TIMEOUT_US  (TO_US)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   always #5 clk = ~clk;

   // Line monitor: phase lengths, release time, pulse counts
   int   cycle = 0;
   int   inh_run = 0, rts_run = 0;
   int   last_inh_len = 0, last_rts_len = 0;
   int   inh_phases = 0;
   int   release_cycle = 0, err_cycle = 0;
   int   done_cnt = 0, err_cnt = 0;
   logic both_seen = 1'b0;
   logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

   always @(negedge clk) begin
      cycle   <= cycle + 1;
      inh_run <= (ps2_clk_oe && !ps2_data_oe) ? inh_run + 1 : 0;
      rts_run <= (ps2_clk_oe && ps2_data_oe) ? rts_run + 1 : 0;
      if (ps2_clk_oe && !prev_clk_oe) inh_phases <= inh_phases + 1;
      if (ps2_clk_oe && ps2_data_oe && !prev_data_oe) last_inh_len <= inh_run;
      if (!ps2_clk_oe && prev_clk_oe) begin
         last_rts_len  <= rts_run;
         release_cycle <= cycle;
      end
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err) begin
         err_cnt   <= err_cnt + 1;
         err_cycle <= cycle;
      end
      if (tx_done && tx_err) both_seen <= 1'b1;
      prev_clk_oe  <= ps2_clk_oe;
      prev_data_oe <= ps2_data_oe;
   end

   logic [9:0] last_bits;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference frame: data LSB first, parity making the ones count odd, stop=1
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      logic [9:0] f;
      f[7:0] = b;
      f[8]   = ($countones(b) % 2 == 0);
      f[9]   = 1'b1;
      return f;
   endfunction

   task automatic send_req(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_release(input string tag);
      int n;
      n = 0;
      while (!ps2_clk_oe && n < INH_CYC + 50) begin tick(); n++; end
      n = 0;
      while (ps2_clk_oe && n < INH_CYC + 50) begin tick(); n++; end
      chk({tag, "_release"}, {ps2_clk_oe, ps2_data_oe}, 2'b01);
   endtask

   // Device clocks n_edges bits; returns right at the 11th rising edge
   task automatic dev_frame(input int h, input bit nack, input int n_edges,
                            input int inject, output logic [9:0] bits);
      bits = '0;
      repeat (h) tick();
      for (int i = 0; i < n_edges; i++) begin
         if (i == 10) dev_data_low = !nack;
         dev_clk_low = 1'b1;
         repeat (h) tick();
         dev_clk_low = 1'b0;
         if (i < 10) bits[i] = ps2_data_in;
         if (i == 10) dev_data_low = 1'b0;
         if (i == inject) begin
            tx_data  = PS2_CMD_RESET;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
         end
         if (i != 10) repeat (h) tick();
      end
   endtask

   task automatic wait_pulse(input int bound, output bit d, output bit e);
      int n;
      n = 0;
      while (!(tx_done || tx_err) && n < bound) begin tick(); n++; end
      d = tx_done;
      e = tx_err;
      chk("pulse_seen", d | e, 1);
   endtask

   task automatic do_xfer(input logic [7:0] b, input bit nack, input int inject, input string tag);
      logic [9:0] bits;
      int h, ph0, d0, e0, tries;
      bit d, e;
      ph0   = inh_phases;
      d0    = done_cnt;
      e0    = err_cnt;
      tries = nack ? ATTEMPTS : 1;
      chk({tag, "_ready_before"}, tx_ready, 1);
      send_req(b);
      for (int a = 0; a < tries; a++) begin
         wait_release(tag);
         chk({tag, "_inhibit_len"}, last_inh_len, INH_CYC);
         chk({tag, "_rts_len"}, last_rts_len, 1);
         h = $urandom_range(12, 30);
         dev_frame(h, nack, 11, inject, bits);
         chk({tag, "_frame"}, bits, frame_of(b));
      end
      last_bits = bits;
      wait_pulse(200, d, e);
      chk({tag, "_done"}, d, !nack);
      chk({tag, "_err"}, e, nack);
      chk({tag, "_ready_on_pulse"}, tx_ready, 0);
      chk({tag, "_lines_idle"}, {ps2_clk_in, ps2_data_in}, 2'b11);
      tick();
      chk({tag, "_ready_after"}, tx_ready, 1);
      chk({tag, "_done_count"}, done_cnt - d0, nack ? 0 : 1);
      chk({tag, "_err_count"}, err_cnt - e0, nack ? 1 : 0);
      chk({tag, "_inhibit_phases"}, inh_phases - ph0, tries);
      $display("xfer %s byte=%02h nack=%0d done=%0d err=%0d", tag, b, nack, d, e);
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] rb;
      bit rn, d, e;
      int ph0, e0, d0;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_done", tx_done, 0);
      chk("rst_err", tx_err, 0);
      rst = 1'b0;
      repeat (3) tick();

      // Enable reporting, ACKed
      do_xfer(PS2_CMD_ENABLE, 1'b0, -1, "f4_ack");
      chk("f4_bits_literal", last_bits, 10'b1_0_1111_0100);

      // All-zero byte needs parity 1
      do_xfer(8'h00, 1'b0, -1, "zero_ack");
      chk("zero_parity", last_bits[8], 1);

      // Set sample rate, NACKed
      do_xfer(PS2_CMD_SET_RATE, 1'b1, -1, "f3_nack");

      // Device never clocks: timeout
      ph0 = inh_phases;
      e0  = err_cnt;
      d0  = done_cnt;
      send_req(PS2_CMD_ENABLE);
      wait_pulse(ATTEMPTS * (TO_CYC + INH_CYC + 50), d, e);
      chk("to_err", e, 1);
      chk("to_done", d, 0);
      chk("to_delay", err_cycle - release_cycle, TO_CYC);
      chk("to_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      chk("to_ready_on_pulse", tx_ready, 0);
      tick();
      chk("to_ready_after", tx_ready, 1);
      chk("to_phases", inh_phases - ph0, ATTEMPTS);
      chk("to_counts", {err_cnt - e0, done_cnt - d0}, {32'd1, 32'd0});
      $display("xfer timeout byte=%02h done=%0d err=%0d", PS2_CMD_ENABLE, d, e);

      // Request while busy is dropped, not queued
      do_xfer(PS2_CMD_ENABLE, 1'b0, 2, "busy_ignore");
      repeat (10) tick();
      chk("busy_no_queue_clk", ps2_clk_oe, 0);
      chk("busy_no_queue_ready", tx_ready, 1);

      // Reset in the middle of SEND releases the lines at once
      send_req(PS2_CMD_ENABLE);
      wait_release("midrst");
      dev_frame(20, 1'b0, 4, -1, bits);
      chk("midrst_bits", bits[3:0], 4'b0100);
      rst = 1'b1;
      #1;
      chk("midrst_clk_oe", ps2_clk_oe, 0);
      chk("midrst_data_oe", ps2_data_oe, 0);
      chk("midrst_ready", tx_ready, 1);
      $display("xfer midrst byte=%02h aborted", PS2_CMD_ENABLE);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      do_xfer(PS2_CMD_ENABLE, 1'b0, -1, "after_rst");

      // Random bytes, random ACK/NACK
      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom);
         rn = ($urandom_range(0, 3) == 0);
         do_xfer(rb, rn, -1, "rand");
      end

      chk("pulse_exclusive", both_seen, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
